// File: rtl/stack_calc_pkg.sv
// Shared constants, state/command enums and the operand-depth helper for the stack calculator.
package stack_calc_pkg;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_PUSH  = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_OUT   = 4'h3;
    localparam logic [3:0] OP_DUP   = 4'h4;
    localparam logic [3:0] OP_SWAP  = 4'h5;
    localparam logic [3:0] OP_OVER  = 4'h6;
    localparam logic [3:0] OP_UNARY = 4'h7;
    localparam logic [3:0] OP_BINA  = 4'h8;
    localparam logic [3:0] OP_MULT  = 4'h9;
    localparam logic [3:0] OP_IDIV  = 4'hA;
    localparam logic [3:0] OP_CLFL  = 4'hB;
    localparam logic [3:0] OP_CLRS  = 4'hC;

    localparam logic [3:0] UN_NOT  = 4'h0;
    localparam logic [3:0] UN_NEG  = 4'h1;
    localparam logic [3:0] UN_INC  = 4'h2;
    localparam logic [3:0] UN_DEC  = 4'h3;
    localparam logic [3:0] UN_SHR  = 4'h4;
    localparam logic [3:0] UN_SHL  = 4'h5;
    localparam logic [3:0] UN_ROR  = 4'h6;
    localparam logic [3:0] UN_ROL  = 4'h7;
    localparam logic [3:0] UN_BREV = 4'h8;

    localparam logic [3:0] BI_ADD  = 4'h0;
    localparam logic [3:0] BI_AND  = 4'h1;
    localparam logic [3:0] BI_OR   = 4'h2;
    localparam logic [3:0] BI_XOR  = 4'h3;
    localparam logic [3:0] BI_ADDC = 4'h4;
    localparam logic [3:0] BI_SUB  = 4'h5;

    localparam int FLAG_UNDER = 3;
    localparam int FLAG_OVER  = 2;
    localparam int FLAG_ERR   = 1;
    localparam int FLAG_CARRY = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_EXEC2 = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_PUSH = 3'd1,
        CMD_POP  = 3'd2,
        CMD_REP1 = 3'd3,
        CMD_REP2 = 3'd4,
        CMD_SWAP = 3'd5,
        CMD_CLR  = 3'd6
    } stk_cmd_t;

    // Without the mul/div unit, opcodes 9/A consume nothing from the stack.
    function automatic logic [1:0] min_depth(input logic [3:0] op, input logic muldiv);
        logic [1:0] n;
        case (op)
            OP_POP, OP_OUT, OP_DUP, OP_UNARY: n = 2'd1;
            OP_SWAP, OP_OVER, OP_BINA:        n = 2'd2;
            OP_MULT, OP_IDIV:                 n = muldiv ? 2'd2 : 2'd0;
            default:                          n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stack_calc_core_if.sv
// Instruction valid/ready port of the stack calculator.
interface stack_calc_core_if #(parameter int WORD_W = 4);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_op;
    logic [3:0]        instr_arg;
    logic [WORD_W-1:0] instr_data;

    modport master (output instr_valid, output instr_op, output instr_arg,
                    output instr_data, input instr_ready);
    modport slave  (input instr_valid, input instr_op, input instr_arg,
                    input instr_data, output instr_ready);
endinterface

// File: rtl/stack_regfile.sv
// Shift-register stack storage; entry 0 is the top and vacated slots always refill with zero,
// so entries beyond the current depth read as 0.
module stack_regfile
    import stack_calc_pkg::*;
#(
    parameter int WORD_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  stk_cmd_t                     i_cmd,
    input  logic [WORD_W-1:0]            i_wdata,
    output logic [WORD_W-1:0]            o_s0,
    output logic [WORD_W-1:0]            o_s1,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth
);
    localparam int DW = $clog2(DEPTH+1);

    logic [WORD_W-1:0] r_stk [DEPTH];
    logic [DW-1:0]     r_depth;

    // Apply one stack command per cycle; the core guarantees depth legality.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
            r_depth <= '0;
        end else begin
            case (i_cmd)
                CMD_PUSH: begin
                    r_stk[0] <= i_wdata;
                    for (int i = 1; i < DEPTH; i++) r_stk[i] <= r_stk[i-1];
                    r_depth <= r_depth + DW'(1);
                end
                CMD_POP: begin
                    for (int i = 0; i < DEPTH-1; i++) r_stk[i] <= r_stk[i+1];
                    r_stk[DEPTH-1] <= '0;
                    r_depth <= r_depth - DW'(1);
                end
                CMD_REP1: r_stk[0] <= i_wdata;
                CMD_REP2: begin
                    r_stk[0] <= i_wdata;
                    for (int i = 1; i < DEPTH-1; i++) r_stk[i] <= r_stk[i+1];
                    r_stk[DEPTH-1] <= '0;
                    r_depth <= r_depth - DW'(1);
                end
                CMD_SWAP: begin
                    r_stk[0] <= r_stk[1];
                    r_stk[1] <= r_stk[0];
                end
                CMD_CLR: begin
                    for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
                    r_depth <= '0;
                end
                default: r_depth <= r_depth;
            endcase
        end
    end

    assign o_s0    = r_stk[0];
    assign o_s1    = r_stk[1];
    assign o_depth = r_depth;
endmodule

// File: rtl/stack_calc_core.sv
// Parametrised stack calculator core: IDLE/EXEC/EXEC2 sequencer around stack_regfile.
// Define STACK_CALC_MULDIV_EN to build the MULT/IDIV unit; otherwise opcodes 9/A only raise error.
module stack_calc_core
    import stack_calc_pkg::*;
#(
    parameter int WORD_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    stack_calc_core_if.slave             instr,
    output logic [WORD_W-1:0]            top,
    output logic [WORD_W-1:0]            second,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic [WORD_W-1:0]            out_reg,
    output logic [3:0]                   flags
);
    localparam int DW = $clog2(DEPTH+1);
`ifdef STACK_CALC_MULDIV_EN
    localparam logic MULDIV = 1'b1;
`else
    localparam logic MULDIV = 1'b0;
`endif

    state_t            r_state, w_nstate;
    logic [3:0]        r_op, r_arg;
    logic [WORD_W-1:0] r_data, r_hi, r_out, w_hi, w_out, w_wdata;
    logic [3:0]        r_flags, w_flags;
    logic              r_pend, w_pend, w_under, w_over, w_grow;
    logic [WORD_W:0]   w_sum;
    stk_cmd_t          w_cmd;

    stack_regfile #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_cmd   (w_cmd),
        .i_wdata (w_wdata),
        .o_s0    (top),
        .o_s1    (second),
        .o_depth (depth)
    );

`ifdef STACK_CALC_MULDIV_EN
    logic [2*WORD_W-1:0] w_prod;
    logic [WORD_W-1:0]   w_quot, w_rem;
    assign w_prod = {{WORD_W{1'b0}}, second} * {{WORD_W{1'b0}}, top};
    assign w_quot = (top == '0) ? '0 : second / top;
    assign w_rem  = (top == '0) ? '0 : second % top;
`endif

    function automatic logic [WORD_W-1:0] unary_f(input logic [WORD_W-1:0] a, input logic [3:0] sel);
        logic [WORD_W-1:0] r;
        r = '0;
        case (sel)
            UN_NOT:  r = ~a;
            UN_NEG:  r = ~a + WORD_W'(1);
            UN_INC:  r = a + WORD_W'(1);
            UN_DEC:  r = a - WORD_W'(1);
            UN_SHR:  r = {1'b0, a[WORD_W-1:1]};
            UN_SHL:  r = {a[WORD_W-2:0], 1'b0};
            UN_ROR:  r = {a[0], a[WORD_W-1:1]};
            UN_ROL:  r = {a[WORD_W-2:0], a[WORD_W-1]};
            UN_BREV: for (int i = 0; i < WORD_W; i++) r[i] = a[WORD_W-1-i];
            default: r = '0;
        endcase
        return r;
    endfunction

    assign w_under = (depth < DW'(min_depth(r_op, MULDIV)));
    assign w_grow  = (r_op == OP_PUSH) || (r_op == OP_DUP) || (r_op == OP_OVER);
    assign w_over  = w_grow && (depth == DW'(DEPTH));
    assign instr.instr_ready = (r_state == ST_IDLE);
    assign out_reg = r_out;
    assign flags   = r_flags;

    // Next state, stack command and flag/output-latch updates for the latched instruction.
    always_comb begin
        w_nstate = r_state;
        w_cmd    = CMD_NONE;
        w_wdata  = '0;
        w_hi     = r_hi;
        w_pend   = 1'b0;
        w_out    = r_out;
        w_flags  = r_flags;
        w_sum    = '0;
        case (r_state)
            ST_IDLE: begin
                if (instr.instr_valid) w_nstate = ST_EXEC;
                else                   w_nstate = ST_IDLE;
            end
            ST_EXEC: begin
                if (MULDIV && (r_op == OP_MULT || r_op == OP_IDIV)) w_nstate = ST_EXEC2;
                else                                                w_nstate = ST_IDLE;
                if (w_under) begin
                    w_flags[FLAG_UNDER] = 1'b1;
                end else if (w_over) begin
                    w_flags[FLAG_OVER] = 1'b1;
                end else begin
                    case (r_op)
                        OP_PUSH:  begin w_cmd = CMD_PUSH; w_wdata = r_data; end
                        OP_POP:   w_cmd = CMD_POP;
                        OP_OUT:   w_out = top;
                        OP_DUP:   begin w_cmd = CMD_PUSH; w_wdata = top; end
                        OP_SWAP:  w_cmd = CMD_SWAP;
                        OP_OVER:  begin w_cmd = CMD_PUSH; w_wdata = second; end
                        OP_UNARY: begin w_cmd = CMD_REP1; w_wdata = unary_f(top, r_arg); end
                        OP_BINA: begin
                            w_cmd = CMD_REP2;
                            case (r_arg)
                                BI_ADD:  w_sum = {1'b0, second} + {1'b0, top};
                                BI_ADDC: w_sum = {1'b0, second} + {1'b0, top}
                                               + {{WORD_W{1'b0}}, r_flags[FLAG_CARRY]};
                                BI_SUB:  w_sum = {1'b0, second} - {1'b0, top};
                                BI_AND:  w_sum = {1'b0, second & top};
                                BI_OR:   w_sum = {1'b0, second | top};
                                BI_XOR:  w_sum = {1'b0, second ^ top};
                                default: w_sum = '0;
                            endcase
                            w_wdata = w_sum[WORD_W-1:0];
                            // Bit WORD_W is carry-out for add and borrow for sub.
                            if (r_arg == BI_ADD || r_arg == BI_ADDC || r_arg == BI_SUB)
                                w_flags[FLAG_CARRY] = w_sum[WORD_W];
                            else
                                w_flags[FLAG_CARRY] = r_flags[FLAG_CARRY];
                        end
`ifdef STACK_CALC_MULDIV_EN
                        OP_MULT: begin
                            w_cmd   = CMD_REP2;
                            w_wdata = w_prod[WORD_W-1:0];
                            w_hi    = w_prod[2*WORD_W-1:WORD_W];
                            w_pend  = 1'b1;
                        end
                        OP_IDIV: begin
                            w_cmd   = CMD_REP2;
                            w_wdata = w_quot;
                            w_hi    = w_rem;
                            w_pend  = 1'b1;
                            if (top == '0) w_flags[FLAG_ERR] = 1'b1;
                            else           w_flags[FLAG_ERR] = r_flags[FLAG_ERR];
                        end
`else
                        OP_MULT, OP_IDIV: w_flags[FLAG_ERR] = 1'b1;
`endif
                        OP_CLFL:  w_flags = 4'b0000;
                        OP_CLRS:  w_cmd = CMD_CLR;
                        default:  w_cmd = CMD_NONE;
                    endcase
                end
            end
            ST_EXEC2: begin
                w_nstate = ST_IDLE;
                if (r_pend) begin
                    w_cmd   = CMD_PUSH;
                    w_wdata = r_hi;
                end else begin
                    w_cmd = CMD_NONE;
                end
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    // Sequencer state, instruction latch, pending high half, output latch and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOOP;
            r_arg   <= 4'h0;
            r_data  <= '0;
            r_hi    <= '0;
            r_pend  <= 1'b0;
            r_out   <= '0;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_nstate;
            r_hi    <= w_hi;
            r_pend  <= w_pend;
            r_out   <= w_out;
            r_flags <= w_flags;
            if (r_state == ST_IDLE && instr.instr_valid) begin
                r_op   <= instr.instr_op;
                r_arg  <= instr.instr_arg;
                r_data <= instr.instr_data;
            end else begin
                r_op   <= r_op;
                r_arg  <= r_arg;
                r_data <= r_data;
            end
        end
    end
endmodule

// File: tb/tb_stack_calc_core.sv
// Directed + randomised bench for stack_calc_core (WORD_W=4, DEPTH=4) against a queue-based model.
module tb_stack_calc_core;
    localparam int W    = 4;
    localparam int D    = 4;
    localparam int MOD  = 1 << W;
`ifdef STACK_CALC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] top, second, out_reg;
    logic [2:0]   depth;
    logic [3:0]   flags;

    stack_calc_core_if #(.WORD_W(W)) bus ();

    stack_calc_core #(.WORD_W(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .instr   (bus),
        .top     (top),
        .second  (second),
        .depth   (depth),
        .out_reg (out_reg),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_check = 0;

    int m_stk[$];
    int m_out = 0;
    bit m_under = 1'b0, m_over = 1'b0, m_err = 1'b0, m_carry = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unary_m(input int a, input int s);
        int r;
        r = 0;
        case (s)
            0: r = MOD - 1 - a;
            1: r = (MOD - a) % MOD;
            2: r = (a + 1) % MOD;
            3: r = (a + MOD - 1) % MOD;
            4: r = a / 2;
            5: r = (a * 2) % MOD;
            6: r = a / 2 + (a % 2) * (MOD / 2);
            7: r = (a * 2) % MOD + a / (MOD / 2);
            8: for (int i = 0; i < W; i++) if (((a >> i) & 1) == 1) r += 1 << (W - 1 - i);
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic model(input int op, input int arg, input int d);
        int n, need, grow, a, b, r;
        n = m_stk.size();
        case (op)
            2, 3, 4, 7: need = 1;
            5, 6, 8:    need = 2;
            9, 10:      need = MD ? 2 : 0;
            default:    need = 0;
        endcase
        grow = (op == 1 || op == 4 || op == 6) ? 1 : 0;
        if (n < need) m_under = 1'b1;
        else if (n + grow > D) m_over = 1'b1;
        else begin
            case (op)
                1: m_stk.push_front(d);
                2: void'(m_stk.pop_front());
                3: m_out = m_stk[0];
                4: m_stk.push_front(m_stk[0]);
                5: begin a = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = a; end
                6: m_stk.push_front(m_stk[1]);
                7: m_stk[0] = unary_m(m_stk[0], arg);
                8: begin
                    b = m_stk.pop_front();
                    a = m_stk.pop_front();
                    case (arg)
                        0: begin r = a + b; m_carry = (r >= MOD); r = r % MOD; end
                        1: r = a & b;
                        2: r = a | b;
                        3: r = a ^ b;
                        4: begin r = a + b + int'(m_carry); m_carry = (r >= MOD); r = r % MOD; end
                        5: begin m_carry = (a < b); r = (a - b + MOD) % MOD; end
                        default: r = 0;
                    endcase
                    m_stk.push_front(r);
                end
                9: if (MD) begin
                    b = m_stk.pop_front(); a = m_stk.pop_front(); r = a * b;
                    m_stk.push_front(r % MOD);
                    m_stk.push_front(r / MOD);
                end else m_err = 1'b1;
                10: if (MD) begin
                    b = m_stk.pop_front(); a = m_stk.pop_front();
                    if (b == 0) begin m_err = 1'b1; m_stk.push_front(0); m_stk.push_front(0); end
                    else begin m_stk.push_front(a / b); m_stk.push_front(a % b); end
                end else m_err = 1'b1;
                11: begin m_under = 1'b0; m_over = 1'b0; m_err = 1'b0; m_carry = 1'b0; end
                12: m_stk.delete();
                default: ;
            endcase
        end
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".top"},    top,     m_stk.size() > 0 ? m_stk[0] : 0);
        check({tag, ".second"}, second,  m_stk.size() > 1 ? m_stk[1] : 0);
        check({tag, ".depth"},  depth,   m_stk.size());
        check({tag, ".out"},    out_reg, m_out);
        check({tag, ".flags"},  flags,   {m_under, m_over, m_err, m_carry});
    endtask

    // Issue one instruction from a negedge, keep valid high until ready returns, then check.
    task automatic exec(input int op, input int arg, input int d);
        int low;
        for (int i = 0; i < 8 && !bus.instr_ready; i++) @(negedge clk);
        bus.instr_op    = op[3:0];
        bus.instr_arg   = arg[3:0];
        bus.instr_data  = d[W-1:0];
        bus.instr_valid = 1'b1;
        @(posedge clk);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_ready) break;
            low++;
        end
        bus.instr_valid = 1'b0;
        check($sformatf("ready_low_cycles.op%0h", op), low, (MD && (op == 9 || op == 10)) ? 2 : 1);
        model(op, arg, d);
        cmp_all($sformatf("op%0h.arg%0h", op, arg));
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = 4'h0;
        bus.instr_arg   = 4'h0;
        bus.instr_data  = '0;
        repeat (2) @(negedge clk);
        check("reset.ready", bus.instr_ready, 1);
        cmp_all("reset");
        rst = 1'b1;
        @(negedge clk);

        exec(1, 0, 3); exec(1, 0, 5); exec(8, 0, 0);
        check("add.top", top, 8); check("add.depth", depth, 1); check("add.carry", flags[0], 0);

        exec(12, 0, 0); exec(1, 0, 15); exec(1, 0, 2); exec(8, 0, 0);
        check("addc.top", top, 1); check("addc.carry", flags[0], 1);
        exec(11, 0, 0);
        check("clfl.flags", flags, 0);

        exec(12, 0, 0); exec(1, 0, 7); exec(1, 0, 6); exec(9, 0, 0);
        check("mult.top", top, MD ? 2 : 6); check("mult.second", second, MD ? 10 : 7);
        check("mult.depth", depth, 2);

        exec(12, 0, 0); exec(11, 0, 0); exec(1, 0, 9); exec(1, 0, 0); exec(10, 0, 0);
        check("div0.top", top, 0); check("div0.second", second, MD ? 0 : 9);
        check("div0.error", flags[1], 1);

        exec(12, 0, 0); exec(11, 0, 0);
        for (int i = 1; i <= 5; i++) exec(1, 0, i);
        check("ovf.depth", depth, 4); check("ovf.top", top, 4); check("ovf.flag", flags[2], 1);
        for (int i = 0; i < 5; i++) exec(2, 0, 0);
        check("udf.depth", depth, 0); check("udf.flag", flags[3], 1);

        for (int k = 0; k < 300; k++)
            exec($urandom_range(0, 15), $urandom_range(0, 10), $urandom_range(0, MOD - 1));

        // Reset asserted while a MULT is in its second execute cycle.
        exec(12, 0, 0); exec(1, 0, 7); exec(1, 0, 6); exec(1, 0, 3); exec(3, 0, 0); exec(2, 0, 0);
        bus.instr_op = 4'h9; bus.instr_arg = 4'h0; bus.instr_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        bus.instr_valid = 1'b0;
        m_stk.delete(); m_out = 0;
        m_under = 1'b0; m_over = 1'b0; m_err = 1'b0; m_carry = 1'b0;
        cmp_all("midmult_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset.ready", bus.instr_ready, 1);
        cmp_all("post_reset");
        exec(1, 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule

// File: doc/stack_calc_core.md
# stack_calc_core

Parametrised successor to the 4-bit stack calculator: a configurable-width, configurable-depth stack machine with a valid/ready instruction port, depth tracking, and overflow/underflow detection. Upstream logic (pin deserialiser or test harness) feeds it one instruction per handshake. Top-of-stack, flags and an output latch go to the output multiplexer and seven-segment decoder.

## Interface
- WORD_W, 4: stack word width in bits (≥2).
- DEPTH, 8: stack capacity in words (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  core can accept an instruction.
- instr_op  in  4  opcode.
- instr_arg  in  4  sub-op selector for UNARY/BINA.
- instr_data  in  WORD_W  PUSH operand.
- top  out  WORD_W  stack[0]; 0 when empty.
- second  out  WORD_W  stack[1]; 0 when depth<2.
- depth  out  $clog2(DEPTH+1)  number of valid entries.
- out_reg  out  WORD_W  output latch, written by OUT.
- flags  out  4  {underflow, overflow, error, carry}; sticky.

## Operation
- States: IDLE, EXEC, EXEC2. instr_ready = (state==IDLE).
- Accept on a clock edge with valid&&ready. Latch op, arg and data, then go to EXEC.
- EXEC applies the op and returns to IDLE. MULT/IDIV instead go EXEC→EXEC2→IDLE.
- Opcodes:
  - 0 NOOP.
  - 1 PUSH data.
  - 2 POP.
  - 3 OUT: out_reg←top.
  - 4 DUP.
  - 5 SWAP.
  - 6 OVER: push second.
  - 7 UNARY: replaces top.
  - 8 BINA: pops 2, pushes 1.
  - 9 MULT.
  - A IDIV.
  - B CLFL: clear all flags.
  - C CLRS: depth←0.
  - D–F NOOP.
- UNARY arg: 0 not, 1 neg, 2 inc, 3 dec, 4 shr1, 5 shl1, 6 ror1, 7 rol1, 8 bit-reverse. Other values give 0.
- BINA computes `second OP top`. arg: 0 add, 1 and, 2 or, 3 xor, 4 add+carry, 5 sub. Other values give 0.
  - add/addc set carry to the carry-out.
  - sub sets carry to the borrow.
  - Logic ops leave carry unchanged.
- MULT: product = second×top, 2·WORD_W bits.
  - EXEC replaces both operands with the low half.
  - EXEC2 pushes the high half.
  - Result: top=high, second=low.
- IDIV: EXEC replaces both operands with quotient second/top. EXEC2 pushes the remainder. Result: top=rem, second=quot.
- Divide by zero: quotient=rem=0, error←1.
- Operand requirements (minimum depth):
  - PUSH: 0.
  - POP, OUT, DUP, UNARY: 1.
  - SWAP, OVER, BINA, MULT, IDIV: 2.
- Underflow: if depth is below an op's minimum, the stack and out_reg are unchanged and underflow←1.
- Net depth growth: +1 for PUSH/DUP/OVER; 0 for MULT/IDIV. Overflow: if growth would exceed DEPTH, the stack is unchanged and overflow←1. A rejected MULT/IDIV skips EXEC2's effect.
- Arithmetic wraps modulo 2^WORD_W.
- Flags clear only on CLFL or reset.

## Timing
- Reset values: state IDLE, instr_ready 1, top/second/depth/out_reg/flags 0. All storage entries are 0.
- Reset is asynchronous at any point, including mid-MULT. The core returns fully to reset values, and no partial result survives.
- Latency:
  - Accepted at edge N: outputs update at edge N+1.
  - MULT/IDIV: partial result at N+1, final at N+2.
  - instr_ready returns high after N+1, or after N+2 for MULT/IDIV.
- Throughput: one single-cycle op every 2 clocks.
- Instruction inputs are ignored while instr_ready is low. Holding instr_valid high causes no repeat acceptance until ready rises.

## Configuration
- STACK_CALC_MULDIV_EN defined: MULT and IDIV implemented as above.
- Not defined: no multiplier/divider hardware.
  - Opcodes 9 and A take one EXEC cycle and leave the stack unchanged.
  - They set error←1.

## Structure
- Shared package stack_calc_pkg holds:
  - Opcode constants OP_*.
  - UNARY/BINA sub-op constants.
  - Flag bit indices.
  - State enum.
- One sub-module, stack_regfile (WORD_W, DEPTH):
  - Shift-register storage.
  - Commands: push, pop, replace-top, replace-two, swap.
  - Outputs stack[0], stack[1] and depth.

## Test plan
- WORD_W=4, DEPTH=4.
- PUSH 3, PUSH 5, BINA/0 → top 8, depth 1, carry 0.
- PUSH F, PUSH 2, BINA/0 → top 1, carry 1. Then CLFL → flags 0.
- PUSH 7, PUSH 6, MULT (macro on) → top 2, second A, depth 2. instr_ready low for exactly 2 cycles.
- IDIV behaviour:
  - Macro on: PUSH 9, PUSH 0, IDIV → top 0, second 0, error 1.
  - Macro off: same sequence → stack 0,9 unchanged, error 1.
- PUSH 1,2,3,4,5 → depth 4, top 4, overflow 1. Then POP×5 → depth 0, underflow 1.
- Assert rst low during EXEC2 of MULT → all outputs 0 immediately. instr_ready 1 after release.
